// File: rtl/spi_master_sequencer.sv
// rtl/spi_master_sequencer.sv - byte-stream sequencer feeding an SPI master through TX/RX FIFOs
//
// Purpose: buffers host bytes in a TX FIFO, launches one master transfer per
// byte, watches the master chip-select for completion and stores the received
// byte in an RX FIFO.
//
// Ports:
//   clk_i, reset_i      shared clock, asynchronous active-high reset
//   wr_en_i, wr_data_i  host push into the TX FIFO; tx_full_o when DEPTH entries held
//   rd_en_i, rd_data_o  host pop from the RX FIFO (first-word fall-through, 0 when empty)
//   rx_empty_o          RX FIFO holds no entries
//   busy_o              sequencer is not idle
//   start_o             one-cycle launch pulse to the master
//   master_din_o        byte to the master, held from launch until the next launch
//   cs_i                master chip-select (active low)
//   master_dout_i       byte received by the master, valid once cs_i returns high
//   clr_flags_i         clears both sticky flags (a simultaneous set wins)
//   tx_overflow_o       sticky: push attempted while the TX FIFO was full
//   err_timeout_o       sticky: cs_i did not fall within CS_TIMEOUT cycles of launch
module spi_master_sequencer #(
  parameter int DEPTH      = 4,
  parameter int CS_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic       tx_full_o,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       rx_empty_o,
  output logic       busy_o,
  output logic       start_o,
  output logic [7:0] master_din_o,
  input  logic       cs_i,
  input  logic [7:0] master_dout_i,
  input  logic       clr_flags_i,
  output logic       tx_overflow_o,
  output logic       err_timeout_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int TW   = $clog2(CS_TIMEOUT + 1);

  localparam logic [CNTW-1:0] FULL_CNT    = CNTW'(DEPTH);
  localparam logic [TW-1:0]   TIMEOUT_CNT = TW'(CS_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_CAPTURE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            cs_q;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic [7:0]      din_q, din_d;
  logic            ovf_q, ovf_d;
  logic            tmo_err_q, tmo_err_d;
  logic            tmo_hit;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]      tx_mem_q [DEPTH];
  logic [AW-1:0]   tx_wr_ptr_q, tx_rd_ptr_q;
  logic [CNTW-1:0] tx_count_q;
  logic            tx_push, tx_pop;

  assign tx_full_o = (tx_count_q == FULL_CNT);
  // Full flag is the registered count, so a push in the cycle a slot frees is still dropped.
  assign tx_push   = wr_en_i && !tx_full_o;
  assign tx_pop    = (state_q == S_LAUNCH);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_q <= tx_count_q + CNTW'(1);
        2'b01:   tx_count_q <= tx_count_q - CNTW'(1);
        default: tx_count_q <= tx_count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wr_data_i;
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]      rx_mem_q [DEPTH];
  logic [AW-1:0]   rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CNTW-1:0] rx_count_q;
  logic            rx_push, rx_pop;

  assign rx_empty_o = (rx_count_q == '0);
  assign rd_data_o  = rx_empty_o ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
  // Space is reserved before launch, so a capture never finds the RX FIFO full.
  assign rx_push    = (state_q == S_CAPTURE);
  assign rx_pop     = rd_en_i && !rx_empty_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_q <= rx_count_q + CNTW'(1);
        2'b01:   rx_count_q <= rx_count_q - CNTW'(1);
        default: rx_count_q <= rx_count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= master_dout_i;
  end

  // ---------------------------------------------------------------- sequencer
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    din_d     = din_q;
    tmo_hit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((tx_count_q != '0) && (rx_count_q < FULL_CNT)) begin
          state_d = S_LAUNCH;
          // Loaded on entry so the byte is already on master_din while start is high.
          din_d   = tx_mem_q[tx_rd_ptr_q];
        end
      end
      S_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!cs_q) begin
          state_d = S_WAIT_HIGH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (tmo_cnt_d == TIMEOUT_CNT) begin
            tmo_hit = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (cs_q) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    start_d   = (state_d == S_LAUNCH);
    busy_d    = (state_d != S_IDLE);
    ovf_d     = (ovf_q && !clr_flags_i) || (wr_en_i && tx_full_o);
    tmo_err_d = (tmo_err_q && !clr_flags_i) || tmo_hit;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
      cs_q      <= 1'b1;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      din_q     <= 8'h00;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      cs_q      <= cs_i;
      start_q   <= start_d;
      busy_q    <= busy_d;
      din_q     <= din_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign master_din_o  = din_q;
  assign tx_overflow_o = ovf_q;
  assign err_timeout_o = tmo_err_q;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// tb/tb_spi_master_sequencer.sv - self-checking bench for spi_master_sequencer
//
// Purpose: drives directed scenarios with random payload bytes against a
// behavioural SPI master whose slave answers every byte with (byte ^ 8'h99).
// Ports: none (top-level bench).
module tb_spi_master_sequencer;

  localparam int DEPTH      = 4;
  localparam int CS_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       busy;
  logic       start;
  logic [7:0] master_din;
  logic       cs;
  logic [7:0] master_dout;
  logic       clr_flags;
  logic       tx_overflow;
  logic       err_timeout;

  always #5 clk = ~clk;

  spi_master_sequencer #(
    .DEPTH      (DEPTH),
    .CS_TIMEOUT (CS_TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .wr_en_i       (wr_en),
    .wr_data_i     (wr_data),
    .tx_full_o     (tx_full),
    .rd_en_i       (rd_en),
    .rd_data_o     (rd_data),
    .rx_empty_o    (rx_empty),
    .busy_o        (busy),
    .start_o       (start),
    .master_din_o  (master_din),
    .cs_i          (cs),
    .master_dout_i (master_dout),
    .clr_flags_i   (clr_flags),
    .tx_overflow_o (tx_overflow),
    .err_timeout_o (err_timeout)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic       master_en = 1'b1;
  int         frame_len = 4;
  logic [7:0] launched [$];
  logic [7:0] m_b;
  logic [7:0] b [6];
  logic [7:0] x0;

  function automatic logic [7:0] slave_resp(input logic [7:0] d);
    return d ^ 8'h99;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic clr);
    wr_en     = 1'b1;
    wr_data   = d;
    clr_flags = clr;
    @(negedge clk);
    wr_en     = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic wait_launches(input int n, input string tag);
    int t = 0;
    while (launched.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, launched.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, busy}, 0);
  endtask

  task automatic pop_check(input logic [7:0] exp, input string tag);
    int t = 0;
    while (rx_empty !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rd_data"}, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Behavioural SPI master: frames last frame_len cycles of cs low.
  initial begin
    cs          = 1'b1;
    master_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && master_en) begin
        m_b = master_din;
        launched.push_back(m_b);
        cs = 1'b0;
        repeat (frame_len) @(negedge clk);
        master_dout = slave_resp(m_b);
        cs = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    rd_en     = 1'b0;
    clr_flags = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_start", {31'd0, start}, 0);
    check("rst_din", master_din, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_tx_full", {31'd0, tx_full}, 0);
    check("rst_rx_empty", {31'd0, rx_empty}, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_ovf", {31'd0, tx_overflow}, 0);
    check("rst_tmo", {31'd0, err_timeout}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte, including the two-cycle launch latency
    launched.delete();
    wr(8'hA5, 1'b0);
    check("single_start_early", {31'd0, start}, 0);
    @(negedge clk);
    check("single_start", {31'd0, start}, 1);
    check("single_din", master_din, 8'hA5);
    wait_launches(1, "single_launch");
    wait_idle("single_idle");
    repeat (3) @(negedge clk);
    check("single_once", launched.size(), 1);
    check("single_rx_nonempty", {31'd0, rx_empty}, 0);
    pop_check(8'h3C, "single");
    check("single_rx_empty", {31'd0, rx_empty}, 1);
    check("single_rd_zero", rd_data, 0);

    // Burst of four random bytes on consecutive cycles
    launched.delete();
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) wr(b[i], 1'b0);
    for (int i = 0; i < 4; i++) pop_check(slave_resp(b[i]), $sformatf("burst%0d", i));
    wait_idle("burst_idle");
    check("burst_count", launched.size(), 4);
    for (int i = 0; i < launched.size() && i < 4; i++)
      check($sformatf("burst_order%0d", i), launched[i], b[i]);
    check("burst_ovf", {31'd0, tx_overflow}, 0);

    // Overflow while the master holds a long frame; set wins over clr_flags
    launched.delete();
    frame_len = 30;
    x0 = 8'($urandom);
    wr(x0, 1'b0);
    wait_launches(1, "ovf_first_launch");
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 4; i++) wr(b[i], 1'b0);
    check("ovf_tx_full", {31'd0, tx_full}, 1);
    check("ovf_flag_pre", {31'd0, tx_overflow}, 0);
    wr(8'hFF, 1'b1);
    check("ovf_flag_set_wins", {31'd0, tx_overflow}, 1);
    check("ovf_still_full", {31'd0, tx_full}, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("ovf_flag_cleared", {31'd0, tx_overflow}, 0);
    frame_len = 4;
    pop_check(slave_resp(x0), "ovf_rx0");
    for (int i = 0; i < 4; i++) pop_check(slave_resp(b[i]), $sformatf("ovf_rx%0d", i + 1));
    wait_idle("ovf_idle");
    check("ovf_count", launched.size(), 5);
    if (launched.size() == 5) begin
      check("ovf_order0", launched[0], x0);
      for (int i = 0; i < 4; i++) check($sformatf("ovf_order%0d", i + 1), launched[i + 1], b[i]);
    end

    // RX backpressure: six bytes, no pops until the sequencer stalls
    launched.delete();
    frame_len = 3;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      int t = 0;
      while (tx_full === 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      wr(b[i], 1'b0);
    end
    wait_launches(4, "bp_four");
    wait_idle("bp_idle4");
    repeat (40) @(negedge clk);
    check("bp_stalled_count", launched.size(), 4);
    check("bp_stalled_busy", {31'd0, busy}, 0);
    check("bp_stalled_tx_full", {31'd0, tx_full}, 0);
    pop_check(slave_resp(b[0]), "bp_rx0");
    wait_launches(5, "bp_five");
    wait_idle("bp_idle5");
    repeat (40) @(negedge clk);
    check("bp_exactly_one_more", launched.size(), 5);
    for (int i = 1; i < 6; i++) pop_check(slave_resp(b[i]), $sformatf("bp_rx%0d", i));
    wait_idle("bp_idle6");
    check("bp_count", launched.size(), 6);
    for (int i = 0; i < launched.size() && i < 6; i++)
      check($sformatf("bp_order%0d", i), launched[i], b[i]);
    check("bp_rx_empty", {31'd0, rx_empty}, 1);

    // Timeout: cs never falls
    launched.delete();
    master_en = 1'b0;
    wr(8'h55, 1'b0);
    @(negedge clk);
    check("tmo_start", {31'd0, start}, 1);
    check("tmo_din", master_din, 8'h55);
    for (int i = 1; i <= CS_TIMEOUT + 1; i++) begin
      @(negedge clk);
      if (i == CS_TIMEOUT) begin
        check("tmo_not_yet", {31'd0, err_timeout}, 0);
        check("tmo_busy_before", {31'd0, busy}, 1);
      end
      if (i == CS_TIMEOUT + 1) begin
        check("tmo_flag", {31'd0, err_timeout}, 1);
        check("tmo_busy_after", {31'd0, busy}, 0);
        check("tmo_rx_unchanged", {31'd0, rx_empty}, 1);
      end
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("tmo_cleared", {31'd0, err_timeout}, 0);
    master_en = 1'b1;

    // Reset during WAIT_HIGH, with TX full
    launched.delete();
    frame_len = 20;
    wr(8'($urandom), 1'b0);
    wait_launches(1, "rst_mid_launch");
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) wr(8'($urandom), 1'b0);
    check("rst_mid_pre_full", {31'd0, tx_full}, 1);
    check("rst_mid_pre_busy", {31'd0, busy}, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_start", {31'd0, start}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_rx_empty", {31'd0, rx_empty}, 1);
    check("rst_mid_tx_full", {31'd0, tx_full}, 0);
    check("rst_mid_din", master_din, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_mid_no_capture", {31'd0, rx_empty}, 1);
    check("rst_mid_idle", {31'd0, busy}, 0);
    check("rst_mid_no_relaunch", launched.size(), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
